// File: rtl/issue_dual_if.sv
// Fetch-side and issue-side signals of the dual-issue dispatch stage.
// The slave modport is the dispatch stage; the master modport is its environment.
interface issue_dual_if;
    logic        fetch_valid;
    logic [31:0] fetch_instr1;
    logic [31:0] fetch_instr2;
    logic        fetch_instr2_valid;
    logic        fetch_ready;
    logic        stall_in;
    logic [31:0] instr1_out;
    logic [31:0] instr2_out;
    logic        issue_valid;
    logic        issue_pair;

    // Handshake: a fetch word pair is accepted on any rising edge where
    // fetch_valid && fetch_ready; stall_in freezes the issue lanes and blocks pops.
    modport slave (
        input  fetch_valid, fetch_instr1, fetch_instr2, fetch_instr2_valid, stall_in,
        output fetch_ready, instr1_out, instr2_out, issue_valid, issue_pair
    );

    modport master (
        output fetch_valid, fetch_instr1, fetch_instr2, fetch_instr2_valid, stall_in,
        input  fetch_ready, instr1_out, instr2_out, issue_valid, issue_pair
    );
endinterface

// File: rtl/issue_dual.sv
// Dual-issue dispatch stage: circular instruction queue feeding a lane1/lane2 pair.
// Optional issue statistics counters are enabled by defining ISSUE_DUAL_STATS_EN.
module issue_dual #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] NOP_WORD = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    issue_dual_if.slave io
`ifdef ISSUE_DUAL_STATS_EN
    ,
    output logic [31:0] pair_count,
    output logic [31:0] single_count
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [QDEPTH];
    logic [31:0]   mem_d [QDEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr1_q, instr1_d;
    logic [31:0]   instr2_q, instr2_d;
    logic          issue_valid_q, issue_valid_d;
    logic          issue_pair_q, issue_pair_d;

    logic          fetch_ready_c;
    logic          push_en, keep1, keep2;
    logic [CW-1:0] pushed, popped;
    logic [31:0]   head_w, next_w;
    logic          pair_ok;

    // Destination register written by a word; 0 means no destination.
    function automatic logic [4:0] dest_of(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        dest_of = 5'd0;
        if (op == 6'h00) begin
            if (fn != 6'h08 && fn != 6'h09) dest_of = w[15:11];
        end else if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23) begin
            dest_of = w[20:16];
        end else if (op == 6'h03) begin
            dest_of = 5'd31;
        end
    endfunction

    function automatic logic is_control(input logic [31:0] w);
        is_control = (w[31:26] >= 6'h02 && w[31:26] <= 6'h07) ||
                     (w[31:26] == 6'h00 && (w[5:0] == 6'h08 || w[5:0] == 6'h09));
    endfunction

    function automatic logic is_mem(input logic [31:0] w);
        is_mem = (w[31:26] == 6'h23) || (w[31:26] == 6'h2B);
    endfunction

    function automatic logic pair_legal(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d1;
        logic [4:0] d2;
        d1 = dest_of(a);
        d2 = dest_of(b);
        pair_legal = 1'b1;
        // Source fields of lane2 are compared whatever its format: conservative RAW.
        if (d1 != 5'd0 && (d1 == b[25:21] || d1 == b[20:16] || d1 == d2)) pair_legal = 1'b0;
        if (is_control(a) || is_control(b)) pair_legal = 1'b0;
        if (is_mem(a) && is_mem(b)) pair_legal = 1'b0;
    endfunction

    always_comb begin
        fetch_ready_c = reset && (count_q <= CW'(QDEPTH - 2));
        push_en       = io.fetch_valid && fetch_ready_c;
        keep1         = push_en && (io.fetch_instr1 != NOP_WORD);
        keep2         = push_en && io.fetch_instr2_valid && (io.fetch_instr2 != NOP_WORD);

        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (keep1) begin
            mem_d[wptr_d] = io.fetch_instr1;
            wptr_d        = wptr_d + PW'(1);
        end
        if (keep2) begin
            mem_d[wptr_d] = io.fetch_instr2;
            wptr_d        = wptr_d + PW'(1);
        end
        pushed = CW'(keep1) + CW'(keep2);

        head_w  = mem_q[rptr_q];
        next_w  = mem_q[rptr_q + PW'(1)];
        pair_ok = (count_q >= CW'(2)) && pair_legal(head_w, next_w);

        instr1_d      = instr1_q;
        instr2_d      = instr2_q;
        issue_valid_d = issue_valid_q;
        issue_pair_d  = issue_pair_q;
        popped        = '0;
        if (!io.stall_in) begin
            if (count_q == '0) begin
                instr1_d      = 32'd0;
                instr2_d      = 32'd0;
                issue_valid_d = 1'b0;
                issue_pair_d  = 1'b0;
            end else if (pair_ok) begin
                instr1_d      = head_w;
                instr2_d      = next_w;
                issue_valid_d = 1'b1;
                issue_pair_d  = 1'b1;
                popped        = CW'(2);
            end else begin
                instr1_d      = head_w;
                instr2_d      = NOP_WORD;
                issue_valid_d = 1'b1;
                issue_pair_d  = 1'b0;
                popped        = CW'(1);
            end
        end
        rptr_d  = rptr_q + popped[PW-1:0];
        count_d = count_q + pushed - popped;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            instr1_q      <= 32'd0;
            instr2_q      <= 32'd0;
            issue_valid_q <= 1'b0;
            issue_pair_q  <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            instr1_q      <= instr1_d;
            instr2_q      <= instr2_d;
            issue_valid_q <= issue_valid_d;
            issue_pair_q  <= issue_pair_d;
        end
    end

    // Storage needs no reset: entries are only read below the registered count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign io.fetch_ready = fetch_ready_c;
    assign io.instr1_out  = instr1_q;
    assign io.instr2_out  = instr2_q;
    assign io.issue_valid = issue_valid_q;
    assign io.issue_pair  = issue_pair_q;

`ifdef ISSUE_DUAL_STATS_EN
    logic [31:0] pair_cnt_q, pair_cnt_d;
    logic [31:0] single_cnt_q, single_cnt_d;

    always_comb begin
        pair_cnt_d   = pair_cnt_q;
        single_cnt_d = single_cnt_q;
        if (!io.stall_in && count_q != '0) begin
            if (pair_ok) pair_cnt_d   = pair_cnt_q + 32'd1;
            else         single_cnt_d = single_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pair_cnt_q   <= 32'd0;
            single_cnt_q <= 32'd0;
        end else begin
            pair_cnt_q   <= pair_cnt_d;
            single_cnt_q <= single_cnt_d;
        end
    end

    assign pair_count   = pair_cnt_q;
    assign single_count = single_cnt_q;
`endif
endmodule

// File: doc/issue_dual.md
Name: issue_dual

Overview:
Dual-issue dispatch stage for the superscalar pipeline. It is the producer of the lane1/lane2 instruction pair consumed by the dual execute stage.
- Buffers fetched MIPS words in a small circular queue.
- Each cycle it issues either a pair or a single instruction.
- Lane2 is forced to nop (32'd0) whenever pairing is illegal.

Parameters:
QDEPTH, 4, instruction queue entries; power of two, >= 2
NOP_WORD, 32'd0, encoding driven on an unused lane and dropped at input

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
fetch_valid  in  1  fetch presents instr words this cycle
fetch_instr1  in  32  older fetched word
fetch_instr2  in  32  younger fetched word
fetch_instr2_valid  in  1  fetch_instr2 is meaningful
fetch_ready  out  1  queue can accept a full fetch pair
stall_in  in  1  downstream stall; hold outputs, no pop
instr1_out  out  32  lane1 instruction (registered)
instr2_out  out  32  lane2 instruction (registered), NOP_WORD if unpaired
issue_valid  out  1  instr1_out is a real issued instruction
issue_pair  out  1  both lanes issued this cycle

Behaviour:
- Reset (reset==0 at edge):
  - Queue empty; read/write pointers = 0.
  - instr1_out = instr2_out = 0; issue_valid = issue_pair = 0.
  - fetch_ready = 0 while reset is low.
- fetch_ready = (free entries >= 2).
  - Computed from the registered count only; a same-cycle pop does not raise it.
- Push occurs when fetch_valid && fetch_ready.
  - instr1 is written first, then instr2 if fetch_instr2_valid.
  - Words equal to NOP_WORD are dropped and never enqueued.
  - Write pointer wraps modulo QDEPTH.
- Push and pop may occur in the same cycle: count_next = count + pushed - popped.
- Issue, when stall_in == 0, is registered at the rising edge:
  - count == 0: outputs = 0, issue_valid = 0.
  - count == 1: instr1_out = head, instr2_out = 0, issue_valid = 1, pop 1.
  - count >= 2 and pair legal: instr1_out = head, instr2_out = head+1, issue_pair = 1, pop 2.
  - count >= 2 and pair illegal: behave as count == 1 (lane2 = NOP_WORD, pop 1).
- stall_in == 1:
  - Outputs and flags hold their values; no pop.
  - Pushes still allowed.
- Latency: a word accepted at edge N can appear on instr1_out at edge N+1 at the earliest.
- Destination of instr1 (dest1):
  - opcode 0: rd, except funct 0x08/0x09 (jr/jalr), which give none.
  - opcodes 0x08–0x0F and 0x23: rt.
  - 0x03 (jal): 31.
  - All others: none.
  - dest 0 is treated as none.
- Pair illegal if any of the following holds:
  - dest1 != none and dest1 equals instr2 rs[25:21] or rt[20:16]. Both fields are compared regardless of instr2 type, so the check is conservative.
  - dest1 != none and dest1 equals dest2 (WAW).
  - Either word is control: opcode 0x02–0x07, or opcode 0 with funct 0x08/0x09.
  - Both are memory ops: opcode 0x23 or 0x2B.
- Program order always preserved: lane1 is older than lane2; nothing is reordered.
- Queue full (count == QDEPTH): fetch_ready = 0; issue continues normally.

Optional Feature:
ISSUE_DUAL_STATS_EN
- Defined:
  - Adds outputs pair_count[31:0] and single_count[31:0].
  - pair_count increments on each pair issue; single_count increments on each single issue.
  - Neither counter increments while stalled.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset low 2 cycles, then high, no fetch -> all outputs 0; fetch_ready = 0 during reset, 1 after.
2. Push 0x00221820 (add $3,$1,$2) with 0x00222820 (add $5,$1,$2) -> next edge: instr1_out = 0x00221820, instr2_out = 0x00222820, issue_pair = 1.
3. Push 0x00221820 with 0x00612020 (add $4,$3,$1; RAW) -> cycle 1: lane1 = 0x00221820, lane2 = 0. Cycle 2: lane1 = 0x00612020, issue_pair = 0.
4. Push 0x10220004 (beq) with 0x00222820 -> beq issues alone; add issues alone on the following cycle. Also push 0x8C260000 (lw) with 0xAC270004 (sw) -> issued as two singles.
5. Hold stall_in = 1 while pushing two pairs -> outputs frozen; fetch_ready falls to 0 at count = 4. Release stall -> pairs drain in order with no loss or duplication.
6. Push a pair where fetch_instr2 = 0 -> only instr1 enqueued (count + 1). With ISSUE_DUAL_STATS_EN defined, after tests 2–3: pair_count = 1, single_count = 2.
